// File: rtl/i2c_config_sequencer_pkg.sv
// Shared types and constants for the I2C configuration table sequencer.
package i2c_config_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CHECK,
    S_DELAY,
    S_NEXT,
    S_FINISH,
    S_FAIL
  } state_t;

  localparam logic [15:0] PTR_END   = 16'hFFFE;
  localparam logic [15:0] PTR_DELAY = 16'hFFFF;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Wide enough for 255 * MS_CYCLES with any 31-bit MS_CYCLES.
  localparam int CNT_W = 40;

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter shared by the delay entries and the handshake timeouts.
module i2c_seq_timer
  import i2c_config_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a ROM table of {pointer, data} entries, issuing engine writes with
// NACK retry, millisecond delays and per-phase handshake timeouts.
//
// state       | meaning
// IDLE        | waiting for a START rising edge
// FETCH       | TBL_ADDR driven, ROM word settling
// DECODE      | classify entry: end marker, delay or write
// ISSUE       | ENG_GO pulse
// WAIT_BUSY   | waiting for engine to drop ENG_END_OK
// WAIT_DONE   | waiting for engine to raise ENG_END_OK
// CHECK       | evaluate ACK, retry or fail
// DELAY       | counting out data*MS_CYCLES
// NEXT        | advance index
// FINISH      | set DONE
// FAIL        | set ERROR and ERR_INDEX
module i2c_config_sequencer
  import i2c_config_sequencer_pkg::*;
#(
  parameter int TABLE_LEN      = 64,
  parameter int MAX_RETRY      = 3,
  parameter int MS_CYCLES      = 50000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic [7:0]  TBL_ADDR,
  input  logic [23:0] TBL_DATA,
  output logic        ENG_GO,
  output logic [15:0] ENG_POINTER,
  output logic [7:0]  ENG_DATA,
  input  logic        ENG_END_OK,
  input  logic        ENG_ACK_OK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  ERR_INDEX,
  output logic [1:0]  ERR_CODE
);

  state_t             state;
  logic               start_q;
  logic [8:0]         index;
  logic [7:0]         retry;
  logic               tmr_load;
  logic               tmr_dec;
  logic [CNT_W-1:0]   tmr_val;
  logic [CNT_W-1:0]   tmr_count;
  logic               tmr_last;
  logic [15:0]        tbl_ptr;
  logic [7:0]         tbl_dat;

  assign tbl_ptr  = TBL_DATA[23:8];
  assign tbl_dat  = TBL_DATA[7:0];
  assign tmr_last = (tmr_count <= CNT_W'(1));

  i2c_seq_timer #(.W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .count    (tmr_count)
  );

  // Each wait phase reloads the timer on entry so the two timeouts are independent.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state)
      S_DECODE: begin
        if (tbl_ptr == PTR_DELAY) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(tbl_dat) * CNT_W'(MS_CYCLES);
        end
      end
      S_ISSUE: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(TIMEOUT_CYCLES);
      end
      S_WAIT_BUSY: begin
        if (!ENG_END_OK) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(TIMEOUT_CYCLES);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_WAIT_DONE, S_DELAY: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      start_q     <= 1'b1;
      index       <= '0;
      retry       <= '0;
      TBL_ADDR    <= '0;
      ENG_GO      <= 1'b0;
      ENG_POINTER <= '0;
      ENG_DATA    <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      ERR_INDEX   <= '0;
      ERR_CODE    <= ERR_NONE;
    end else begin
      start_q <= START;
      ENG_GO  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && !start_q) begin
            index     <= '0;
            retry     <= '0;
            TBL_ADDR  <= '0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
            ERR_INDEX <= '0;
            ERR_CODE  <= ERR_NONE;
            BUSY      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (tbl_ptr == PTR_END) begin
            state <= S_FINISH;
          end else if (tbl_ptr == PTR_DELAY) begin
            state <= (tbl_dat == 8'd0) ? S_NEXT : S_DELAY;
          end else begin
            ENG_POINTER <= tbl_ptr;
            ENG_DATA    <= tbl_dat;
            ENG_GO      <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!ENG_END_OK) begin
            state <= S_WAIT_DONE;
          end else if (tmr_last) begin
            ERR_CODE <= ERR_TIMEOUT;
            state    <= S_FAIL;
          end
        end
        S_WAIT_DONE: begin
          if (ENG_END_OK) begin
            state <= S_CHECK;
          end else if (tmr_last) begin
            ERR_CODE <= ERR_TIMEOUT;
            state    <= S_FAIL;
          end
        end
        S_CHECK: begin
          if (ENG_ACK_OK) begin
            state <= S_NEXT;
          end else if (int'(retry) < MAX_RETRY) begin
            retry  <= retry + 8'd1;
            ENG_GO <= 1'b1;
            state  <= S_ISSUE;
          end else begin
            ERR_CODE <= ERR_NACK;
            state    <= S_FAIL;
          end
        end
        S_DELAY: if (tmr_last) state <= S_NEXT;
        S_NEXT: begin
          retry    <= '0;
          index    <= index + 9'd1;
          TBL_ADDR <= 8'(index + 9'd1);
          state    <= ((index + 9'd1) == 9'(TABLE_LEN)) ? S_FINISH : S_FETCH;
        end
        S_FINISH: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        S_FAIL: begin
          ERROR     <= 1'b1;
          ERR_INDEX <= index[7:0];
          BUSY      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: ROM + engine model, directed table, random runs.
module tb_i2c_config_sequencer;
  localparam int TL  = 8;
  localparam int MR  = 3;
  localparam int MS  = 10;
  localparam int TMO = 64;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  TBL_ADDR;
  logic [23:0] TBL_DATA;
  logic        ENG_GO;
  logic [15:0] ENG_POINTER;
  logic [7:0]  ENG_DATA;
  logic        ENG_END_OK;
  logic        ENG_ACK_OK;
  logic        BUSY, DONE, ERROR;
  logic [7:0]  ERR_INDEX;
  logic [1:0]  ERR_CODE;

  always #5 CLK = ~CLK;

  i2c_config_sequencer #(.TABLE_LEN(TL), .MAX_RETRY(MR), .MS_CYCLES(MS), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .ENG_GO(ENG_GO), .ENG_POINTER(ENG_POINTER), .ENG_DATA(ENG_DATA), .ENG_END_OK(ENG_END_OK),
    .ENG_ACK_OK(ENG_ACK_OK), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_INDEX(ERR_INDEX),
    .ERR_CODE(ERR_CODE)
  );

  int tests = 0;
  int fails = 0;

  logic [23:0] rom [0:255];
  bit          ack_seq [0:63];
  int          hang;  // 0 normal, 1 never drops END_OK, 2 never raises it again

  int          go_count, go_wide, stab_bad, cyc;
  logic [15:0] go_ptr [0:63];
  logic [7:0]  go_dat [0:63];
  int          go_time [0:63];

  int          m_go_n;
  logic [15:0] m_ptr [0:63];
  logic [7:0]  m_dat [0:63];
  bit          m_done, m_err;
  logic [1:0]  m_code;
  logic [7:0]  m_idx;

  typedef struct {
    logic [23:0] e0, e1, e2;
    int          nack_from, nacks;
    int          go_n;
    bit          done, err;
    logic [1:0]  code;
    logic [7:0]  idx;
  } vec_t;
  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ROM and engine model; everything here reacts on the falling edge.
  initial begin
    int phase, ecnt;
    bit cur_ack, prev_go;
    logic [15:0] cap_ptr;
    logic [7:0]  cap_dat;
    phase = 0; ecnt = 0; cur_ack = 1'b0; prev_go = 1'b0; cap_ptr = '0; cap_dat = '0;
    ENG_END_OK = 1'b1; ENG_ACK_OK = 1'b0; TBL_DATA = '0;
    go_count = 0; go_wide = 0; stab_bad = 0; cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      TBL_DATA = rom[TBL_ADDR];
      if (!RESET_N) begin
        phase = 0; ENG_END_OK = 1'b1; ENG_ACK_OK = 1'b0;
        go_count = 0; go_wide = 0; stab_bad = 0; prev_go = 1'b0;
      end else begin
        if (ENG_GO && prev_go) go_wide++;
        prev_go = ENG_GO;
        case (phase)
          0: if (ENG_GO && hang != 1) begin
               cap_ptr = ENG_POINTER; cap_dat = ENG_DATA;
               cur_ack = (go_count < 64) ? ack_seq[go_count] : 1'b1;
               ecnt = $urandom_range(0, 2); phase = 1;
             end
          1: if (ecnt == 0) begin
               ENG_END_OK = 1'b0; ENG_ACK_OK = 1'b0;
               ecnt = $urandom_range(0, 3); phase = 2;
             end else ecnt--;
          2: if (hang != 2) begin
               if (ecnt == 0) begin
                 if ({ENG_POINTER, ENG_DATA} !== {cap_ptr, cap_dat}) stab_bad++;
                 ENG_END_OK = 1'b1; ENG_ACK_OK = cur_ack; phase = 0;
               end else ecnt--;
             end
          default: phase = 0;
        endcase
        if (ENG_GO) begin
          if (go_count < 64) begin
            go_ptr[go_count] = ENG_POINTER; go_dat[go_count] = ENG_DATA; go_time[go_count] = cyc;
          end
          go_count++;
        end
      end
    end
  end

  task automatic load_rom(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
    for (int i = 0; i < 256; i++) rom[i] = {16'h4000 + 16'(i), 8'(i)};
    rom[0] = e0; rom[1] = e1; rom[2] = e2;
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(DONE || ERROR) && n < budget) begin @(negedge CLK); n++; end
    if (n >= budget) chk({tag, "_run_end"}, DONE | ERROR, 1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_go(input string tag, input int goal, input int budget);
    int n = 0;
    while (go_count < goal && n < budget) begin @(negedge CLK); n++; end
    if (n >= budget) chk({tag, "_go_seen"}, 64'(go_count), 64'(goal));
  endtask

  task automatic check_common(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_go_wide"}, 64'(go_wide), 0);
    chk({tag, "_ptr_stable"}, 64'(stab_bad), 0);
  endtask

  // Reference: walk the table applying retry and end rules to the scripted ACKs.
  task automatic model();
    int idx = 0;
    int k = 0;
    bit ok;
    m_done = 0; m_err = 0; m_code = 2'd0; m_idx = 8'd0;
    while (!m_done && !m_err) begin
      if (idx == TL) m_done = 1;
      else if (rom[idx][23:8] == 16'hFFFE) m_done = 1;
      else if (rom[idx][23:8] == 16'hFFFF) idx++;
      else begin
        ok = 0;
        for (int a = 0; a <= MR && !ok; a++) begin
          m_ptr[k] = rom[idx][23:8]; m_dat[k] = rom[idx][7:0];
          ok = ack_seq[k]; k++;
        end
        if (!ok) begin m_err = 1; m_code = 2'd1; m_idx = 8'(idx); end
        else idx++;
      end
    end
    m_go_n = k;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int n, gap;
    string t;
    vecs[0] = '{24'h300882, 24'hFFFE00, 24'h000000, 0, 0, 1, 1'b1, 1'b0, 2'd0, 8'd0};
    vecs[1] = '{24'h123455, 24'hFFFE00, 24'h000000, 0, 4, 4, 1'b0, 1'b1, 2'd1, 8'd0};
    vecs[2] = '{24'h123455, 24'hFFFE00, 24'h000000, 0, 3, 4, 1'b1, 1'b0, 2'd0, 8'd0};
    vecs[3] = '{24'h123455, 24'h222266, 24'hFFFE00, 0, 2, 4, 1'b1, 1'b0, 2'd0, 8'd0};
    vecs[4] = '{24'hFFFF00, 24'h010101, 24'hFFFE00, 0, 0, 1, 1'b1, 1'b0, 2'd0, 8'd0};
    vecs[5] = '{24'h010101, 24'h020202, 24'h030303, 0, 0, 8, 1'b1, 1'b0, 2'd0, 8'd0};
    vecs[6] = '{24'h555501, 24'h666602, 24'hFFFE00, 1, 4, 5, 1'b0, 1'b1, 2'd1, 8'd1};

    hang = 0;
    for (int k = 0; k < 64; k++) ack_seq[k] = 1'b1;
    load_rom(24'hFFFE00, 24'hFFFE00, 24'hFFFE00);

    #1 RESET_N = 1'b0;
    #11;
    chk("reset_outputs", {ENG_GO, BUSY, DONE, ERROR, ERR_INDEX, ERR_CODE, TBL_ADDR, ENG_POINTER, ENG_DATA}, '0);
    @(negedge CLK); RESET_N = 1'b1;

    for (int v = 0; v < NV; v++) begin
      load_rom(vecs[v].e0, vecs[v].e1, vecs[v].e2);
      for (int k = 0; k < 64; k++)
        ack_seq[k] = !(k >= vecs[v].nack_from && k < vecs[v].nack_from + vecs[v].nacks);
      do_reset();
      pulse_start();
      @(negedge CLK);
      t = $sformatf("vec%0d", v);
      chk({t, "_busy_run"}, BUSY, 1);
      wait_end(t, 3000);
      chk({t, "_go_n"}, 64'(go_count), 64'(vecs[v].go_n));
      chk({t, "_done"}, DONE, vecs[v].done);
      chk({t, "_error"}, ERROR, vecs[v].err);
      chk({t, "_err_code"}, ERR_CODE, vecs[v].code);
      chk({t, "_err_index"}, ERR_INDEX, vecs[v].idx);
      check_common(t);
      if (v == 0) chk("vec0_go_word", {go_ptr[0], go_dat[0]}, {16'h3008, 8'h82});
    end

    // Delay entry of 3 units between two writes; a START while busy must be ignored.
    for (int k = 0; k < 64; k++) ack_seq[k] = 1'b1;
    load_rom(24'h111101, 24'hFFFF03, 24'h222202);
    rom[3] = 24'hFFFE00;
    do_reset();
    pulse_start();
    wait_go("delay", 1, 200);
    pulse_start();
    wait_end("delay", 3000);
    chk("delay_go_n", 64'(go_count), 2);
    chk("delay_done", DONE, 1);
    gap = go_time[1] - go_time[0];
    chk("delay_gap_in_range", (gap >= 3 * MS) && (gap <= 3 * MS + 25), 1);
    check_common("delay");

    // Engine never drops END_OK: WAIT_BUSY timeout on entry 1.
    load_rom(24'hFFFF00, 24'h777707, 24'hFFFE00);
    do_reset();
    hang = 1;
    pulse_start();
    wait_go("tmo_busy", 1, 200);
    n = 0;
    while (!ERROR && n < 4 * TMO) begin @(negedge CLK); n++; end
    chk("tmo_busy_cycles_in_range", (n >= TMO - 2) && (n <= TMO + 6), 1);
    wait_end("tmo_busy", 100);
    chk("tmo_busy_error", ERROR, 1);
    chk("tmo_busy_code", ERR_CODE, 2);
    chk("tmo_busy_index", ERR_INDEX, 1);
    chk("tmo_busy_go_n", 64'(go_count), 1);
    chk("tmo_busy_done", DONE, 0);

    // Engine drops END_OK and never finishes: WAIT_DONE timeout.
    load_rom(24'h777707, 24'hFFFE00, 24'hFFFE00);
    do_reset();
    hang = 2;
    pulse_start();
    wait_end("tmo_done", 1000);
    chk("tmo_done_error", ERROR, 1);
    chk("tmo_done_code", ERR_CODE, 2);
    chk("tmo_done_index", ERR_INDEX, 0);

    // Reset while waiting for completion.
    load_rom(24'h300882, 24'hFFFE00, 24'hFFFE00);
    do_reset();
    hang = 2;
    pulse_start();
    n = 0;
    while (ENG_END_OK && n < 50) begin @(negedge CLK); n++; end
    chk("rst_engine_busy", ENG_END_OK, 0);
    repeat (3) @(negedge CLK);
    chk("rst_busy_before", BUSY, 1);
    @(posedge CLK); #2 RESET_N = 1'b0;
    #1 chk("rst_async_outputs",
           {ENG_GO, BUSY, DONE, ERROR, ERR_INDEX, ERR_CODE, TBL_ADDR, ENG_POINTER, ENG_DATA}, '0);
    hang = 0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK);
    chk("rst_no_go_after", 64'(go_count), 0);
    chk("rst_idle_busy", BUSY, 0);
    pulse_start();
    wait_end("rst_rerun", 1000);
    chk("rst_rerun_done", DONE, 1);
    chk("rst_rerun_go_n", 64'(go_count), 1);

    // Random tables and ACK scripts against the reference walk.
    for (int r = 0; r < 25; r++) begin
      int sel;
      for (int i = 0; i < TL; i++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      rom[i] = 24'hFFFE00;
        else if (sel == 1) rom[i] = {16'hFFFF, 8'($urandom_range(0, 2))};
        else               rom[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom_range(0, 255))};
      end
      for (int k = 0; k < 64; k++) ack_seq[k] = ($urandom_range(0, 99) >= 25);
      model();
      do_reset();
      pulse_start();
      t = $sformatf("rnd%0d", r);
      wait_end(t, 3000);
      chk({t, "_go_n"}, 64'(go_count), 64'(m_go_n));
      for (int k = 0; k < m_go_n && k < go_count && k < 64; k++)
        chk($sformatf("%s_go%0d", t, k), {go_ptr[k], go_dat[k]}, {m_ptr[k], m_dat[k]});
      chk({t, "_done"}, DONE, m_done);
      chk({t, "_error"}, ERROR, m_err);
      if (m_err) begin
        chk({t, "_err_code"}, ERR_CODE, m_code);
        chk({t, "_err_index"}, ERR_INDEX, m_idx);
      end
      check_common(t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 Parameter TABLE_LEN, default 64, maximum number of table entries; 2..256.
REQ-002 Parameter MAX_RETRY, default 3, re-issues allowed per entry after a failed ACK.
REQ-003 Parameter MS_CYCLES, default 50000, CLK cycles per delay unit.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, maximum wait per engine handshake phase.
REQ-005 CLK  input  1  engine clock; all logic on the rising edge.
REQ-006 RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 START  input  1  rising edge begins a table run.
REQ-008 TBL_ADDR  output  8  table ROM address.
REQ-009 TBL_DATA  input  24  ROM word {pointer[15:0], data[7:0]}; valid 1 cycle after TBL_ADDR changes.
REQ-010 ENG_GO  output  1  start strobe to the I2C write engine.
REQ-011 ENG_POINTER  output  16  register pointer to the engine.
REQ-012 ENG_DATA  output  8  data byte to the engine.
REQ-013 ENG_END_OK  input  1  engine idle/complete; high when idle.
REQ-014 ENG_ACK_OK  input  1  engine ACK result; valid while ENG_END_OK is high after a transaction.
REQ-015 BUSY  output  1  run in progress.
REQ-016 DONE  output  1  sticky; run completed without error.
REQ-017 ERROR  output  1  sticky; run aborted.
REQ-018 ERR_INDEX  output  8  table index of the failing entry.
REQ-019 ERR_CODE  output  2  failure code: 1 = NACK after retries, 2 = handshake timeout.

Function
REQ-020 States: IDLE, FETCH, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, DELAY, NEXT, FINISH, FAIL.
REQ-021 IDLE transition: IDLE to FETCH on a START rising edge, with index = 0, retry = 0, DONE = 0, ERROR = 0 and BUSY = 1; START edges while BUSY are ignored.
REQ-022 FETCH: drive TBL_ADDR = index and wait one cycle; DECODE then latches TBL_DATA.
REQ-023 DECODE, end marker: pointer 16'hFFFE goes to FINISH.
REQ-024 DECODE, delay entry: pointer 16'hFFFF goes to DELAY for data*MS_CYCLES cycles; data = 0 means zero delay and goes straight to NEXT.
REQ-025 DECODE, write entry: any other pointer loads ENG_POINTER/ENG_DATA and goes to ISSUE.
REQ-026 ISSUE: ENG_GO high for exactly one cycle, then WAIT_BUSY.
REQ-027 WAIT_BUSY: wait for ENG_END_OK = 0, then WAIT_DONE.
REQ-028 WAIT_DONE: wait for ENG_END_OK = 1, then CHECK.
REQ-029 Timeout: each of WAIT_BUSY and WAIT_DONE gets its own counter; reaching TIMEOUT_CYCLES goes to FAIL with ERR_CODE = 2.
REQ-030 CHECK, ACK good: ENG_ACK_OK = 1 goes to NEXT.
REQ-031 CHECK, NACK: if retry < MAX_RETRY, retry++ and return to ISSUE; otherwise FAIL with ERR_CODE = 1.
REQ-032 NEXT: retry = 0, index++; index reaching TABLE_LEN (wrap boundary) goes to FINISH, otherwise FETCH.
REQ-033 FINISH: DONE = 1, BUSY = 0, return to IDLE.
REQ-034 FAIL: ERROR = 1, ERR_INDEX = index, BUSY = 0, return to IDLE.
REQ-035 Stability: ENG_POINTER/ENG_DATA hold stable from ISSUE through CHECK.
REQ-036 ENG_GO is never high outside ISSUE.
REQ-037 Delay counter width: at least 24 bits; the product data*MS_CYCLES is computed without overflow.

Reset
REQ-038 On RESET_N low, immediately: state = IDLE, and all of ENG_GO, BUSY, DONE, ERROR, ERR_INDEX, ERR_CODE, TBL_ADDR, ENG_POINTER, ENG_DATA, counters and retry = 0.
REQ-039 Reset mid-run abandons the run with no further ENG_GO; a new START is required after release.

Structure
REQ-040 Shared package holds the state encoding, the marker constants 16'hFFFE/16'hFFFF and the ERR_CODE values.
REQ-041 One sub-module, i2c_seq_timer: a loadable down-counter shared by DELAY and the timeouts.

Verification
REQ-042 Table {0x3008/0x82, 0xFFFE}, engine model ACKs -> one ENG_GO, ENG_POINTER = 0x3008, ENG_DATA = 0x82, DONE = 1, ERROR = 0.
REQ-043 Entry 0 NACKed 4 times, MAX_RETRY = 3 -> four ENG_GO pulses, ERROR = 1, ERR_CODE = 1, ERR_INDEX = 0.
REQ-044 Entry NACKed twice then ACKed -> three ENG_GO pulses, run continues, DONE = 1.
REQ-045 Delay entry 0xFFFF/3 with MS_CYCLES = 10 -> gap between surrounding ENG_GO pulses of at least 30 cycles.
REQ-046 Engine never drops ENG_END_OK -> FAIL after TIMEOUT_CYCLES, ERR_CODE = 2.
REQ-047 RESET_N low during WAIT_DONE -> all outputs 0 immediately; no ENG_GO until a new START.
